// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds dispatched integer ops in age order, snoops
// the CDB for pending source tags and hands the oldest fully-ready op to the
// ALU through a registered output stage with a valid/ready handshake.
module alu_issue_queue #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic                       Clk,
   input  logic                       Resetn,
   input  logic                       Flush,
   // dispatch side
   input  logic                       Disp_Valid,
   output logic                       Disp_Ready,
   input  logic [3:0]                 Disp_Opcode,
   input  logic [TAG_W-1:0]           Disp_Tag,
   input  logic [4:0]                 Disp_Shfamt,
   input  logic                       Disp_Op1_Valid,
   input  logic                       Disp_Op2_Valid,
   input  logic [DATA_W-1:0]          Disp_Op1,
   input  logic [DATA_W-1:0]          Disp_Op2,
   input  logic [TAG_W-1:0]           Disp_Op1_Tag,
   input  logic [TAG_W-1:0]           Disp_Op2_Tag,
   // common data bus
   input  logic                       CDB_Valid,
   input  logic [TAG_W-1:0]           CDB_Tag,
   input  logic [DATA_W-1:0]          CDB_Data,
   // ALU side
   output logic                       ALU_Valid,
   input  logic                       ALU_Ready,
   output logic [DATA_W-1:0]          Operand1,
   output logic [DATA_W-1:0]          Operand2,
   output logic [4:0]                 Shfamt,
   output logic [TAG_W-1:0]           Tag_In,
   output logic [3:0]                 ALU_Opcode,
   // occupancy (output stage excluded)
   output logic [$clog2(DEPTH+1)-1:0] Count
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic [3:0]        opcode;
      logic [TAG_W-1:0]  tag;
      logic [4:0]        shfamt;
      logic              op1_v;
      logic [DATA_W-1:0] op1;
      logic [TAG_W-1:0]  op1_tag;
      logic              op2_v;
      logic [DATA_W-1:0] op2;
      logic [TAG_W-1:0]  op2_tag;
   } entry_t;

   // Entries are compacted toward index 0, so slot i is occupied exactly
   // when i < count_q; no separate per-entry valid flag is stored.
   entry_t            q      [DEPTH];
   entry_t            q_snoop[DEPTH];
   entry_t            q_next [DEPTH];
   entry_t            disp_entry;

   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_next;
   logic [CNT_W-1:0]  wr_idx;
   logic [DEPTH-1:0]  ready;
   logic              any_ready;
   logic [IDX_W-1:0]  issue_idx;
   logic              load_slot;
   logic              issue;
   logic              disp_accept;

   assign Disp_Ready  = (count_q < CNT_W'(DEPTH));
   assign Count       = count_q;
   assign load_slot   = !ALU_Valid || ALU_Ready;
   assign issue       = load_slot && any_ready;
   assign disp_accept = Disp_Valid && Disp_Ready;

   // Readiness uses registered operand state only, so a same-cycle CDB
   // capture cannot make an entry issuable until the following cycle.
   always_comb begin
      ready = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ready[i] = (CNT_W'(i) < count_q) && q[i].op1_v && q[i].op2_v;
      end
   end

   // Oldest-first select: lowest ready index wins.
   always_comb begin
      issue_idx = '0;
      any_ready = 1'b0;
      for (int unsigned i = DEPTH; i > 0; i--) begin
         if (ready[i-1]) begin
            issue_idx = IDX_W'(i - 1);
            any_ready = 1'b1;
         end
      end
   end

   // CDB snoop on resident entries; both operands may capture together.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         q_snoop[i] = q[i];
         if (CDB_Valid && !q[i].op1_v && (q[i].op1_tag == CDB_Tag)) begin
            q_snoop[i].op1_v = 1'b1;
            q_snoop[i].op1   = CDB_Data;
         end
         if (CDB_Valid && !q[i].op2_v && (q[i].op2_tag == CDB_Tag)) begin
            q_snoop[i].op2_v = 1'b1;
            q_snoop[i].op2   = CDB_Data;
         end
      end
   end

   // Build the incoming entry, forwarding a same-cycle CDB broadcast.
   always_comb begin
      disp_entry.opcode  = Disp_Opcode;
      disp_entry.tag     = Disp_Tag;
      disp_entry.shfamt  = Disp_Shfamt;
      disp_entry.op1_v   = Disp_Op1_Valid;
      disp_entry.op1     = Disp_Op1;
      disp_entry.op1_tag = Disp_Op1_Tag;
      disp_entry.op2_v   = Disp_Op2_Valid;
      disp_entry.op2     = Disp_Op2;
      disp_entry.op2_tag = Disp_Op2_Tag;
      if (!Disp_Op1_Valid && CDB_Valid && (Disp_Op1_Tag == CDB_Tag)) begin
         disp_entry.op1_v = 1'b1;
         disp_entry.op1   = CDB_Data;
      end
      if (!Disp_Op2_Valid && CDB_Valid && (Disp_Op2_Tag == CDB_Tag)) begin
         disp_entry.op2_v = 1'b1;
         disp_entry.op2   = CDB_Data;
      end
   end

   // Compact over the issued slot, then append the dispatched entry at the
   // post-compaction tail. Snoop results ride along with the shift.
   always_comb begin : compact_p
      logic [IDX_W-1:0] src;
      for (int unsigned j = 0; j < DEPTH; j++) begin
         src = IDX_W'(j);
         if (issue && (IDX_W'(j) >= issue_idx) && (j + 1 < DEPTH)) begin
            src = IDX_W'(j + 1);
         end
         q_next[j] = q_snoop[src];
      end
      wr_idx = count_q - CNT_W'(issue);
      if (disp_accept) begin
         for (int unsigned j = 0; j < DEPTH; j++) begin
            if (CNT_W'(j) == wr_idx) begin
               q_next[j] = disp_entry;
            end
         end
      end
      count_next = wr_idx + CNT_W'(disp_accept);
   end

   // Entry storage; occupancy is governed by count_q, so no reset needed.
   always_ff @(posedge Clk) begin
      q <= q_next;
   end

   // Occupancy and output stage; output registers hold while stalled.
   always_ff @(posedge Clk) begin
      if (!Resetn) begin
         count_q    <= '0;
         ALU_Valid  <= 1'b0;
         Operand1   <= '0;
         Operand2   <= '0;
         Shfamt     <= '0;
         Tag_In     <= '0;
         ALU_Opcode <= '0;
      end else if (Flush) begin
         count_q    <= '0;
         ALU_Valid  <= 1'b0;
      end else begin
         count_q <= count_next;
         if (load_slot) begin
            ALU_Valid <= issue;
            if (issue) begin
               Operand1   <= q[issue_idx].op1;
               Operand2   <= q[issue_idx].op2;
               Shfamt     <= q[issue_idx].shfamt;
               Tag_In     <= q[issue_idx].tag;
               ALU_Opcode <= q[issue_idx].opcode;
            end
         end
      end
   end

   // Occupancy must stay within the physical entry count.
   always_ff @(posedge Clk) begin
      if (Resetn) begin
         assert (count_q <= CNT_W'(DEPTH));
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_alu_issue_queue;

   localparam int DEPTH  = 4;
   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int CW     = $clog2(DEPTH+1);

   logic              Clk, Resetn, Flush;
   logic              Disp_Valid, Disp_Ready;
   logic [3:0]        Disp_Opcode;
   logic [TAG_W-1:0]  Disp_Tag;
   logic [4:0]        Disp_Shfamt;
   logic              Disp_Op1_Valid, Disp_Op2_Valid;
   logic [DATA_W-1:0] Disp_Op1, Disp_Op2;
   logic [TAG_W-1:0]  Disp_Op1_Tag, Disp_Op2_Tag;
   logic              CDB_Valid;
   logic [TAG_W-1:0]  CDB_Tag;
   logic [DATA_W-1:0] CDB_Data;
   logic              ALU_Valid, ALU_Ready;
   logic [DATA_W-1:0] Operand1, Operand2;
   logic [4:0]        Shfamt;
   logic [TAG_W-1:0]  Tag_In;
   logic [3:0]        ALU_Opcode;
   logic [CW-1:0]     Count;

   int n_checks = 0;
   int n_fail   = 0;

   alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .Clk(Clk), .Resetn(Resetn), .Flush(Flush),
      .Disp_Valid(Disp_Valid), .Disp_Ready(Disp_Ready),
      .Disp_Opcode(Disp_Opcode), .Disp_Tag(Disp_Tag), .Disp_Shfamt(Disp_Shfamt),
      .Disp_Op1_Valid(Disp_Op1_Valid), .Disp_Op2_Valid(Disp_Op2_Valid),
      .Disp_Op1(Disp_Op1), .Disp_Op2(Disp_Op2),
      .Disp_Op1_Tag(Disp_Op1_Tag), .Disp_Op2_Tag(Disp_Op2_Tag),
      .CDB_Valid(CDB_Valid), .CDB_Tag(CDB_Tag), .CDB_Data(CDB_Data),
      .ALU_Valid(ALU_Valid), .ALU_Ready(ALU_Ready),
      .Operand1(Operand1), .Operand2(Operand2), .Shfamt(Shfamt),
      .Tag_In(Tag_In), .ALU_Opcode(ALU_Opcode), .Count(Count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [3:0]        opc;
      logic [TAG_W-1:0]  tag;
      logic [4:0]        shf;
      bit                v1, v2;
      logic [DATA_W-1:0] d1, d2;
      logic [TAG_W-1:0]  t1, t2;
   } m_entry_t;

   m_entry_t mq[$];
   bit       m_alu_valid = 1'b0;
   m_entry_t m_out;

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      m_entry_t e;
      int  sel;
      bit  slot, accept;
      if (!Resetn || Flush) begin
         mq.delete();
         m_alu_valid = 1'b0;
         if (!Resetn) begin
            m_out.opc = '0; m_out.tag = '0; m_out.shf = '0;
            m_out.d1  = '0; m_out.d2  = '0;
         end
         return;
      end
      slot   = !m_alu_valid || ALU_Ready;
      accept = Disp_Valid && (mq.size() < DEPTH);
      sel    = -1;
      foreach (mq[i]) if (sel < 0 && mq[i].v1 && mq[i].v2) sel = i;
      foreach (mq[i]) begin
         if (CDB_Valid && !mq[i].v1 && mq[i].t1 == CDB_Tag) begin mq[i].v1 = 1; mq[i].d1 = CDB_Data; end
         if (CDB_Valid && !mq[i].v2 && mq[i].t2 == CDB_Tag) begin mq[i].v2 = 1; mq[i].d2 = CDB_Data; end
      end
      if (slot) begin
         if (sel >= 0) begin
            m_out = mq[sel];
            mq.delete(sel);
            m_alu_valid = 1'b1;
         end else begin
            m_alu_valid = 1'b0;
         end
      end
      if (accept) begin
         e.opc = Disp_Opcode; e.tag = Disp_Tag; e.shf = Disp_Shfamt;
         e.v1 = Disp_Op1_Valid; e.d1 = Disp_Op1; e.t1 = Disp_Op1_Tag;
         e.v2 = Disp_Op2_Valid; e.d2 = Disp_Op2; e.t2 = Disp_Op2_Tag;
         if (!e.v1 && CDB_Valid && e.t1 == CDB_Tag) begin e.v1 = 1; e.d1 = CDB_Data; end
         if (!e.v2 && CDB_Valid && e.t2 == CDB_Tag) begin e.v2 = 1; e.d2 = CDB_Data; end
         mq.push_back(e);
      end
   endtask

   // One clock: update the model, pass the edge, settle away from it.
   task automatic cycle();
      model_step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_inputs();
      Flush = 0; Disp_Valid = 0; Disp_Opcode = '0; Disp_Tag = '0; Disp_Shfamt = '0;
      Disp_Op1_Valid = 0; Disp_Op2_Valid = 0; Disp_Op1 = '0; Disp_Op2 = '0;
      Disp_Op1_Tag = '0; Disp_Op2_Tag = '0; CDB_Valid = 0; CDB_Tag = '0; CDB_Data = '0;
   endtask

   task automatic drive_disp(input logic [3:0] opc, input logic [TAG_W-1:0] tag,
                             input bit v1, input logic [DATA_W-1:0] d1, input logic [TAG_W-1:0] t1,
                             input bit v2, input logic [DATA_W-1:0] d2, input logic [TAG_W-1:0] t2);
      Disp_Valid = 1; Disp_Opcode = opc; Disp_Tag = tag; Disp_Shfamt = 5'd0;
      Disp_Op1_Valid = v1; Disp_Op1 = d1; Disp_Op1_Tag = t1;
      Disp_Op2_Valid = v2; Disp_Op2 = d2; Disp_Op2_Tag = t2;
   endtask

   task automatic drain();
      clear_inputs();
      ALU_Ready = 1;
      repeat (3) cycle();
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      clear_inputs();
      ALU_Ready = 0;
      Resetn = 0;
      repeat (2) cycle();
      Resetn = 1;
      n_checks++; if (ALU_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_alu_valid got=%b exp=0", ALU_Valid); end
      n_checks++; if (Count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", Count); end
      n_checks++; if (Disp_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got=%b exp=1", Disp_Ready); end
      n_checks++; if ({Operand1, Operand2, Shfamt, Tag_In, ALU_Opcode} !== '0)
         begin n_fail++; $display("FAIL reset_outputs got=%h/%h/%h/%h/%h exp=0", Operand1, Operand2, Shfamt, Tag_In, ALU_Opcode); end
   endtask

   task automatic test_add();
      ALU_Ready = 1;
      drive_disp(4'd2, 5'd3, 1, 32'd5, '0, 1, 32'd7, '0);
      cycle();
      clear_inputs();
      n_checks++; if (Count !== CW'(1)) begin n_fail++; $display("FAIL add_count_q got=%0d exp=1", Count); end
      n_checks++; if (ALU_Valid !== 1'b0) begin n_fail++; $display("FAIL add_early got=%b exp=0", ALU_Valid); end
      cycle();
      n_checks++; if (ALU_Valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got=%b exp=1", ALU_Valid); end
      n_checks++; if ({Operand1, Operand2, Tag_In, ALU_Opcode} !== {32'd5, 32'd7, 5'd3, 4'd2})
         begin n_fail++; $display("FAIL add_fields got=%0d/%0d/%0d/%0d exp=5/7/3/2", Operand1, Operand2, Tag_In, ALU_Opcode); end
      n_checks++; if (Count !== CW'(0)) begin n_fail++; $display("FAIL add_count_end got=%0d exp=0", Count); end
      drain();
   endtask

   task automatic test_cdb_wakeup();
      ALU_Ready = 1;
      drive_disp(4'd3, 5'd4, 1, 32'h20, '0, 0, '0, 5'd9);
      cycle();
      clear_inputs();
      cycle();
      CDB_Valid = 1; CDB_Tag = 5'd9; CDB_Data = 32'h10;
      cycle();
      clear_inputs();
      n_checks++; if (ALU_Valid !== 1'b0) begin n_fail++; $display("FAIL wake_capture_cycle got=%b exp=0", ALU_Valid); end
      cycle();
      n_checks++; if (ALU_Valid !== 1'b1 || Tag_In !== 5'd4) begin n_fail++; $display("FAIL wake_issue got=%b/%0d exp=1/4", ALU_Valid, Tag_In); end
      n_checks++; if (Operand2 !== 32'h10 || Operand1 !== 32'h20) begin n_fail++; $display("FAIL wake_operands got=%h/%h exp=20/10", Operand1, Operand2); end
      drain();
   endtask

   task automatic test_dispatch_forward();
      ALU_Ready = 1;
      drive_disp(4'd1, 5'd11, 0, '0, 5'd6, 1, 32'h3, '0);
      CDB_Valid = 1; CDB_Tag = 5'd6; CDB_Data = 32'hAB;
      cycle();
      clear_inputs();
      n_checks++; if (ALU_Valid !== 1'b0 || Count !== CW'(1)) begin n_fail++; $display("FAIL fwd_written got=%b/%0d exp=0/1", ALU_Valid, Count); end
      cycle();
      n_checks++; if (ALU_Valid !== 1'b1 || Operand1 !== 32'hAB || Tag_In !== 5'd11)
         begin n_fail++; $display("FAIL fwd_issue got=%b/%h/%0d exp=1/ab/11", ALU_Valid, Operand1, Tag_In); end
      drain();
   endtask

   task automatic test_back_to_back();
      ALU_Ready = 0;
      for (int k = 1; k <= 5; k++) begin
         drive_disp(4'd0, TAG_W'(k), 1, 32'(k * 16), '0, 1, 32'(k), '0);
         cycle();
         if (k == 4) begin
            n_checks++; if (Count !== CW'(3)) begin n_fail++; $display("FAIL b2b_count3 got=%0d exp=3", Count); end
         end
      end
      n_checks++; if (Count !== CW'(4) || Disp_Ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got=%0d/%b exp=4/0", Count, Disp_Ready); end
      drive_disp(4'd0, 5'd6, 1, '0, '0, 1, '0, '0);
      cycle();
      clear_inputs();
      n_checks++; if (Count !== CW'(4) || Tag_In !== 5'd1 || ALU_Valid !== 1'b1)
         begin n_fail++; $display("FAIL b2b_stall got=%0d/%0d/%b exp=4/1/1", Count, Tag_In, ALU_Valid); end
      ALU_Ready = 1;
      for (int k = 1; k <= 5; k++) begin
         n_checks++; if (ALU_Valid !== 1'b1 || Tag_In !== TAG_W'(k))
            begin n_fail++; $display("FAIL b2b_order got=%b/%0d exp=1/%0d", ALU_Valid, Tag_In, k); end
         cycle();
      end
      n_checks++; if (ALU_Valid !== 1'b0 || Count !== CW'(0)) begin n_fail++; $display("FAIL b2b_empty got=%b/%0d exp=0/0", ALU_Valid, Count); end
      drain();
   endtask

   task automatic test_age_bypass();
      ALU_Ready = 1;
      drive_disp(4'd5, 5'd7, 0, '0, 5'd12, 1, 32'h1, '0);
      cycle();
      drive_disp(4'd6, 5'd8, 1, 32'h2, '0, 1, 32'h3, '0);
      cycle();
      clear_inputs();
      cycle();
      n_checks++; if (ALU_Valid !== 1'b1 || Tag_In !== 5'd8) begin n_fail++; $display("FAIL age_younger got=%b/%0d exp=1/8", ALU_Valid, Tag_In); end
      CDB_Valid = 1; CDB_Tag = 5'd12; CDB_Data = 32'h55;
      cycle();
      clear_inputs();
      n_checks++; if (ALU_Valid !== 1'b0) begin n_fail++; $display("FAIL age_gap got=%b exp=0", ALU_Valid); end
      cycle();
      n_checks++; if (ALU_Valid !== 1'b1 || Tag_In !== 5'd7 || Operand1 !== 32'h55)
         begin n_fail++; $display("FAIL age_older got=%b/%0d/%h exp=1/7/55", ALU_Valid, Tag_In, Operand1); end
      drain();
   endtask

   task automatic test_flush(input bit use_reset);
      ALU_Ready = 0;
      drive_disp(4'd2, 5'd1, 1, 32'h1, '0, 1, 32'h1, '0);
      cycle();
      for (int k = 2; k <= 4; k++) begin
         drive_disp(4'd2, TAG_W'(k), 0, '0, 5'd13, 1, 32'h2, '0);
         cycle();
      end
      n_checks++; if (Count !== CW'(3) || ALU_Valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got=%0d/%b exp=3/1", Count, ALU_Valid); end
      drive_disp(4'd2, 5'd20, 1, '0, '0, 1, '0, '0);
      if (use_reset) Resetn = 0; else Flush = 1;
      cycle();
      clear_inputs();
      Resetn = 1;
      n_checks++; if (Count !== CW'(0) || ALU_Valid !== 1'b0 || Disp_Ready !== 1'b1)
         begin n_fail++; $display("FAIL flush_clear rst=%0d got=%0d/%b/%b exp=0/0/1", use_reset, Count, ALU_Valid, Disp_Ready); end
      ALU_Ready = 1;
      CDB_Valid = 1; CDB_Tag = 5'd13; CDB_Data = 32'h77;
      cycle();
      clear_inputs();
      for (int k = 0; k < 2; k++) begin
         cycle();
         n_checks++; if (ALU_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost rst=%0d got=%b exp=0", use_reset, ALU_Valid); end
      end
      drain();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         Flush          = ($urandom_range(0, 99) < 3);
         Disp_Valid     = ($urandom_range(0, 99) < 65);
         Disp_Opcode    = 4'($urandom_range(0, 15));
         Disp_Tag       = TAG_W'($urandom_range(0, 31));
         Disp_Shfamt    = 5'($urandom_range(0, 31));
         Disp_Op1_Valid = ($urandom_range(0, 99) < 60);
         Disp_Op2_Valid = ($urandom_range(0, 99) < 60);
         Disp_Op1       = $urandom;
         Disp_Op2       = $urandom;
         Disp_Op1_Tag   = TAG_W'($urandom_range(0, 7));
         Disp_Op2_Tag   = TAG_W'($urandom_range(0, 7));
         CDB_Valid      = ($urandom_range(0, 99) < 50);
         CDB_Tag        = TAG_W'($urandom_range(0, 7));
         CDB_Data       = $urandom;
         ALU_Ready      = ($urandom_range(0, 99) < 70);
         cycle();
         n_checks++; if (ALU_Valid !== m_alu_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, ALU_Valid, m_alu_valid); end
         n_checks++; if (Count !== CW'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, Count, mq.size()); end
         n_checks++; if (Disp_Ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b", c, Disp_Ready); end
         if (m_alu_valid) begin
            n_checks++;
            if ({Operand1, Operand2, Shfamt, Tag_In, ALU_Opcode} !== {m_out.d1, m_out.d2, m_out.shf, m_out.tag, m_out.opc})
               begin n_fail++; $display("FAIL rnd_out c=%0d got=%h/%h/%0d/%0d/%0d exp=%h/%h/%0d/%0d/%0d", c,
                  Operand1, Operand2, Shfamt, Tag_In, ALU_Opcode, m_out.d1, m_out.d2, m_out.shf, m_out.tag, m_out.opc); end
         end
      end
      drain();
   endtask

   initial begin
      clear_inputs();
      Resetn = 0;
      ALU_Ready = 0;
      test_reset();
      test_add();
      test_cdb_wakeup();
      test_dispatch_forward();
      test_back_to_back();
      test_age_bypass();
      test_flush(1'b0);
      test_flush(1'b1);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Integer reservation station that sits between dispatch and the ALU in the Tomasulo pipeline.
- Accepts decoded ALU ops with renamed operands, snoops the CDB for pending operand tags, and presents the oldest fully-ready op to the ALU.
- ALU-facing signals are Operand1, Operand2, Shfamt, Tag_In and ALU_Opcode.
- The ALU is the consumer; this block is the producer of ALU inputs.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAG_W, 5, tag width.
- DATA_W, 32, operand width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Resetn  in  1  synchronous active-low reset.
- Flush  in  1  synchronous clear of all entries and of the output stage (branch mispredict).
- Disp_Valid  in  1  dispatch request.
- Disp_Ready  out  1  queue can accept; equals (count < DEPTH).
- Disp_Opcode  in  4  ALU opcode.
- Disp_Tag  in  TAG_W  destination tag.
- Disp_Shfamt  in  5  shift amount.
- Disp_Op1_Valid, Disp_Op2_Valid  in  1 each  operand value present.
- Disp_Op1, Disp_Op2  in  DATA_W each  operand value, used when valid.
- Disp_Op1_Tag, Disp_Op2_Tag  in  TAG_W each  producer tag, used when not valid.
- CDB_Valid  in  1  result broadcast.
- CDB_Tag  in  TAG_W  broadcast tag.
- CDB_Data  in  DATA_W  broadcast value.
- ALU_Valid  out  1  output stage holds an op.
- ALU_Ready  in  1  ALU accepts the op this cycle.
- Operand1, Operand2  out  DATA_W each  to ALU.
- Shfamt  out  5  to ALU.
- Tag_In  out  TAG_W  to ALU Tag_In.
- ALU_Opcode  out  4  to ALU.
- Count  out  $clog2(DEPTH+1)  occupied entries, excluding the output stage.

Behaviour:
- Reset: Resetn=0 at a clock edge sets all entry valid bits to 0, ALU_Valid=0, Count=0, and Operand1/Operand2/Shfamt/Tag_In/ALU_Opcode=0. Disp_Ready therefore reads 1. Reset mid-operation discards everything.
- Flush: same clear as reset, but data registers may be left as they are. Flush has priority over dispatch, CDB capture and issue in the same cycle.
- Ordering: entries are kept age-ordered; index 0 is the oldest. On removal, younger entries shift down by one in the same cycle. A new entry is written at index Count after compaction.
- Dispatch: accepted when Disp_Valid && Disp_Ready. Disp_Ready uses the pre-cycle Count, so a full queue refuses dispatch even if an issue frees a slot that cycle.
- Dispatch-time CDB forward: if a dispatched operand is not valid, CDB_Valid=1 and CDB_Tag equals that operand's tag, the entry stores CDB_Data and marks the operand valid.
- Snoop: each cycle, every valid entry with a pending operand whose tag equals CDB_Tag (CDB_Valid=1) captures CDB_Data. Both operands of one entry may capture simultaneously.
- Ready definition: an entry is ready when both operands are valid as registered at the start of the cycle. An operand captured this cycle makes the entry ready next cycle.
- Output stage:
  - A load slot exists when ALU_Valid=0 or ALU_Ready=1.
  - When a load slot exists, the lowest-index ready entry moves into the output registers and leaves the queue, and ALU_Valid=1 next cycle.
  - If a load slot exists but no entry is ready, ALU_Valid=0 next cycle.
  - While ALU_Valid=1 and ALU_Ready=0, all output registers hold stable.
- Latency: an op dispatched with both operands valid at edge N (empty queue, free output stage) shows ALU_Valid=1 after edge N+1.
- Count update: Count_next = Count + dispatch_accepted - issued. Count never exceeds DEPTH or underflows.
- Simultaneous events: dispatch, CDB capture, compaction and issue all occur in one cycle without losing or duplicating an entry. The entry written this cycle is never issued in the same cycle.
- Throughput: one issue per cycle when ALU_Ready is held at 1.

Test Plan:
- Reset then dispatch ADD (opcode 2, tag 3, Op1=5, Op2=7, both valid) with ALU_Ready=1 -> ALU_Valid=1 one cycle later with Operand1=5, Operand2=7, Tag_In=3, ALU_Opcode=2; Count returns to 0.
- Dispatch SUB (tag 4) with Op2 pending tag 9, then CDB_Valid=1, tag 9, data 0x10 two cycles later -> issue occurs the cycle after capture with Operand2=0x10.
- Dispatch with Op1 pending tag 6 while CDB_Valid=1, CDB_Tag=6, data 0xAB in the same cycle -> entry ready next cycle and issues with Operand1=0xAB.
- Hold ALU_Ready=0 and dispatch 4 ready ops (tags 1..4) -> the first fills the output stage, Count reaches 3 and then 4 after a fifth dispatch, Disp_Ready=0, output stays tag 1. Then release ALU_Ready -> tags issue in order 1,2,3,4,5, one per cycle.
- Older entry blocked (pending tag 12) and younger entry ready -> younger issues first; the older issues after the CDB delivers tag 12.
- Three entries queued with ALU_Valid=1, then assert Flush (or Resetn=0) -> next cycle Count=0, ALU_Valid=0, Disp_Ready=1, and a subsequent CDB with the pending tag produces no issue.
